// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller.
//  - DEF_RESET_PC / DEF_CNT_W : default parameter values
//  - npc_sel_e                : next-PC source encoding (0 +4, 1 br, 2 jal, 3 jr)
//  - sel_rank                 : priority rank of a source (higher wins)
package pc_fetch_ctrl_pkg;

  localparam int unsigned DEF_PC_W     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int unsigned DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JAL = 2'd2,
    SEL_JR  = 2'd3
  } npc_sel_e;

  // Encodings are ordered so that the rank is the encoding itself: jr > jal > br > +4.
  function automatic logic [1:0] sel_rank(input npc_sel_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_npc_prio_sel.sv
// Combinational priority pick among the three D-stage redirect requests.
// Ports:
//  br_req/br_tgt, jal_req/jal_tgt, jr_req/jr_tgt : request pulses and targets
//  win_vld  : at least one request is live
//  win_sel  : winning source (jr > jal > br)
//  win_tgt  : winning target with bits [1:0] cleared
//  misalign : winning target had nonzero bits [1:0]
//  multi    : two or more requests live at once
module pc_fetch_ctrl_npc_prio_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W
) (
  input  logic            br_req,
  input  logic [PC_W-1:0] br_tgt,
  input  logic            jal_req,
  input  logic [PC_W-1:0] jal_tgt,
  input  logic            jr_req,
  input  logic [PC_W-1:0] jr_tgt,
  output logic            win_vld,
  output npc_sel_e        win_sel,
  output logic [PC_W-1:0] win_tgt,
  output logic            misalign,
  output logic            multi
);

  logic [PC_W-1:0] raw_tgt;

  always_comb begin
    win_sel = SEL_SEQ;
    raw_tgt = '0;
    if (jr_req) begin
      win_sel = SEL_JR;
      raw_tgt = jr_tgt;
    end else if (jal_req) begin
      win_sel = SEL_JAL;
      raw_tgt = jal_tgt;
    end else if (br_req) begin
      win_sel = SEL_BR;
      raw_tgt = br_tgt;
    end
    win_vld  = br_req | jal_req | jr_req;
    misalign = win_vld && (raw_tgt[1:0] != 2'b00);
    win_tgt  = {raw_tgt[PC_W-1:2], 2'b00};
    multi    = (2'(br_req) + 2'(jal_req) + 2'(jr_req)) >= 2'd2;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC register with redirect arbitration and stall buffering.
// Ports:
//  clk, reset                : clock, async active-high reset
//  stall_F                   : hold PC this cycle
//  br/jal/jr_req_D, *_tgt_D  : one-cycle redirect requests from D
//  pc_F, pc_plus4_F          : current fetch PC and PC+4
//  npc_sel                   : source loading pc_F at the coming edge (combinational)
//  pend_vld                  : a redirect is buffered awaiting stall release
//  align_err, multi_err      : sticky error flags
//  redir_cnt                 : saturating count of applied redirects
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned     CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_F,
  input  logic             br_req_D,
  input  logic [PC_W-1:0]  br_tgt_D,
  input  logic             jal_req_D,
  input  logic [PC_W-1:0]  jal_tgt_D,
  input  logic             jr_req_D,
  input  logic [PC_W-1:0]  jr_tgt_D,
  output logic [PC_W-1:0]  pc_F,
  output logic [PC_W-1:0]  pc_plus4_F,
  output logic [1:0]       npc_sel,
  output logic             pend_vld,
  output logic             align_err,
  output logic             multi_err,
  output logic [CNT_W-1:0] redir_cnt
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

  state_e          state_q, state_nxt;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_nxt;
  npc_sel_e        pend_sel_q, pend_sel_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  npc_sel_e        sel_c;
  logic            redirect, align_set, live_wins;

  logic            win_vld, misalign, multi;
  npc_sel_e        win_sel;
  logic [PC_W-1:0] win_tgt;

  pc_fetch_ctrl_npc_prio_sel #(.PC_W(PC_W)) u_prio (
    .br_req   (br_req_D),
    .br_tgt   (br_tgt_D),
    .jal_req  (jal_req_D),
    .jal_tgt  (jal_tgt_D),
    .jr_req   (jr_req_D),
    .jr_tgt   (jr_tgt_D),
    .win_vld  (win_vld),
    .win_sel  (win_sel),
    .win_tgt  (win_tgt),
    .misalign (misalign),
    .multi    (multi)
  );

  assign pc_plus4_F = pc_F + PC_W'(4);
  assign pend_vld   = (state_q == PEND);
  assign npc_sel    = sel_c;

  // Live request displaces the buffered one on equal or higher rank.
  assign live_wins = win_vld && (sel_rank(win_sel) >= sel_rank(pend_sel_q));

  // Next-state, next-PC and pend-register selection.
  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc_F;
    pend_tgt_nxt = pend_tgt_q;
    pend_sel_nxt = pend_sel_q;
    sel_c        = SEL_SEQ;
    redirect     = 1'b0;
    align_set    = 1'b0;
    case (state_q)
      RUN: begin
        if (!stall_F) begin
          if (win_vld) begin
            pc_nxt    = win_tgt;
            sel_c     = win_sel;
            redirect  = 1'b1;
            align_set = misalign;
          end else begin
            pc_nxt = pc_F + PC_W'(4);
          end
        end else if (win_vld) begin
          pend_tgt_nxt = win_tgt;
          pend_sel_nxt = win_sel;
          align_set    = misalign;
          state_nxt    = PEND;
        end
      end
      PEND: begin
        if (stall_F) begin
          if (live_wins) begin
            pend_tgt_nxt = win_tgt;
            pend_sel_nxt = win_sel;
            align_set    = misalign;
          end
        end else begin
          if (live_wins) begin
            pc_nxt    = win_tgt;
            sel_c     = win_sel;
            align_set = misalign;
          end else begin
            pc_nxt = pend_tgt_q;
            sel_c  = pend_sel_q;
          end
          redirect  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    cnt_nxt = redir_cnt;
    if (redirect && (redir_cnt != {CNT_W{1'b1}})) cnt_nxt = redir_cnt + CNT_W'(1);
  end

  // State, PC, pend register, sticky flags and counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      pc_F       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_sel_q <= SEL_SEQ;
      align_err  <= 1'b0;
      multi_err  <= 1'b0;
      redir_cnt  <= '0;
    end else begin
      state_q    <= state_nxt;
      pc_F       <= pc_nxt;
      pend_tgt_q <= pend_tgt_nxt;
      pend_sel_q <= pend_sel_nxt;
      align_err  <= align_err | align_set;
      multi_err  <= multi_err | multi;
      redir_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural model of the fetch-PC rules.
module tb_pc_fetch_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int          CNT_MAX = 15;

  logic        clk;
  logic        reset;
  logic        stall_F;
  logic        br_req_D, jal_req_D, jr_req_D;
  logic [31:0] br_tgt_D, jal_tgt_D, jr_tgt_D;
  logic [31:0] pc_F, pc_plus4_F;
  logic [1:0]  npc_sel;
  logic        pend_vld, align_err, multi_err;
  logic [CNT_W-1:0] redir_cnt;

  pc_fetch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_F    (stall_F),
    .br_req_D   (br_req_D),
    .br_tgt_D   (br_tgt_D),
    .jal_req_D  (jal_req_D),
    .jal_tgt_D  (jal_tgt_D),
    .jr_req_D   (jr_req_D),
    .jr_tgt_D   (jr_tgt_D),
    .pc_F       (pc_F),
    .pc_plus4_F (pc_plus4_F),
    .npc_sel    (npc_sel),
    .pend_vld   (pend_vld),
    .align_err  (align_err),
    .multi_err  (multi_err),
    .redir_cnt  (redir_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: PC, one buffered redirect (priority + target), flags, count.
  logic [31:0] m_pc;
  bit          m_pend;
  int          m_pend_prio;
  logic [31:0] m_pend_tgt;
  bit          m_align, m_multi;
  int          m_cnt;
  int          exp_sel;
  logic [1:0]  obs_sel;

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_pend = 0; m_pend_prio = 0; m_pend_tgt = '0;
    m_align = 0; m_multi = 0; m_cnt = 0; exp_sel = 0;
  endtask

  task automatic set_idle();
    stall_F = 0; br_req_D = 0; jal_req_D = 0; jr_req_D = 0;
    br_tgt_D = '0; jal_tgt_D = '0; jr_tgt_D = '0;
  endtask

  // Assert reset asynchronously; caller checks, then calls release_reset.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle();
  endtask

  // One clock: drive inputs just after an edge, sample npc_sel, advance model, settle after edge.
  task automatic step(input bit st, input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt, input bit r, input logic [31:0] rt);
    int wp;
    logic [31:0] wt;
    stall_F = st; br_req_D = b; br_tgt_D = bt; jal_req_D = j; jal_tgt_D = jt;
    jr_req_D = r; jr_tgt_D = rt;
    wp = 0; wt = '0;
    if (b) begin wp = 1; wt = bt; end
    if (j) begin wp = 2; wt = jt; end
    if (r) begin wp = 3; wt = rt; end
    exp_sel = 0;
    if (st) begin
      if (wp != 0 && (!m_pend || wp >= m_pend_prio)) begin
        m_pend = 1; m_pend_prio = wp; m_pend_tgt = wt & 32'hFFFF_FFFC;
        if (wt % 4 != 0) m_align = 1;
      end
    end else begin
      if (wp != 0 && (!m_pend || wp >= m_pend_prio)) begin
        exp_sel = wp; m_pc = wt & 32'hFFFF_FFFC;
        if (wt % 4 != 0) m_align = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else if (m_pend) begin
        exp_sel = m_pend_prio; m_pc = m_pend_tgt;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_pend = 0;
    end
    if (int'(b) + int'(j) + int'(r) >= 2) m_multi = 1;
    #2 obs_sel = npc_sel;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    #1;
    do_reset();
    n_cmp++; if (pc_F !== 32'h3000) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_F, 32'h3000); end
    n_cmp++; if (pc_plus4_F !== 32'h3004) begin n_err++; $display("FAIL reset_plus4: got %h want %h", pc_plus4_F, 32'h3004); end
    n_cmp++; if ({pend_vld, align_err, multi_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {pend_vld, align_err, multi_err}); end
    n_cmp++; if (redir_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", redir_cnt); end
    n_cmp++; if (npc_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", npc_sel); end
    release_reset();
  endtask

  task automatic test_sequential_and_branch();
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc_F !== 32'h3004 || obs_sel !== 2'd0) begin n_err++; $display("FAIL seq1: got pc=%h sel=%0d want 3004/0", pc_F, obs_sel); end
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc_F !== 32'h3008) begin n_err++; $display("FAIL seq2: got %h want 3008", pc_F); end
    step(0, 1, 32'h3040, 0, 0, 0, 0);
    n_cmp++; if (obs_sel !== 2'd1) begin n_err++; $display("FAIL br_sel: got %0d want 1", obs_sel); end
    n_cmp++; if (pc_F !== 32'h3040 || pc_plus4_F !== 32'h3044) begin n_err++; $display("FAIL br_pc: got %h/%h want 3040/3044", pc_F, pc_plus4_F); end
    n_cmp++; if (redir_cnt !== 4'd1) begin n_err++; $display("FAIL br_cnt: got %0d want 1", redir_cnt); end
  endtask

  task automatic test_multi();
    step(0, 1, 32'h3300, 1, 32'h3200, 1, 32'h3100);
    n_cmp++; if (pc_F !== 32'h3100 || obs_sel !== 2'd3) begin n_err++; $display("FAIL multi_pc: got %h sel=%0d want 3100/3", pc_F, obs_sel); end
    n_cmp++; if (multi_err !== 1'b1) begin n_err++; $display("FAIL multi_err: got %b want 1", multi_err); end
  endtask

  task automatic test_stall_redirect();
    step(1, 0, 0, 1, 32'h3400, 0, 0);
    n_cmp++; if (pc_F !== 32'h3100 || pend_vld !== 1'b1 || obs_sel !== 2'd0) begin n_err++; $display("FAIL stall1: got pc=%h pend=%b sel=%0d want 3100/1/0", pc_F, pend_vld, obs_sel); end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (pc_F !== 32'h3100 || pend_vld !== 1'b1) begin n_err++; $display("FAIL stall_hold: got pc=%h pend=%b want 3100/1", pc_F, pend_vld); end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc_F !== 32'h3400 || obs_sel !== 2'd2) begin n_err++; $display("FAIL stall_rel: got pc=%h sel=%0d want 3400/2", pc_F, obs_sel); end
    n_cmp++; if (pend_vld !== 1'b0 || redir_cnt !== 4'd3) begin n_err++; $display("FAIL stall_rel_state: got pend=%b cnt=%0d want 0/3", pend_vld, redir_cnt); end
  endtask

  task automatic test_pend_priority();
    step(1, 0, 0, 1, 32'h3600, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h3500);
    n_cmp++; if (pc_F !== 32'h3500 || obs_sel !== 2'd3 || pend_vld !== 1'b0) begin n_err++; $display("FAIL live_wins: got pc=%h sel=%0d pend=%b want 3500/3/0", pc_F, obs_sel, pend_vld); end
    step(1, 0, 0, 1, 32'h3700, 0, 0);
    step(1, 1, 32'h3800, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h3900, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc_F !== 32'h3900 || obs_sel !== 2'd2) begin n_err++; $display("FAIL pend_tie: got pc=%h sel=%0d want 3900/2", pc_F, obs_sel); end
    step(1, 0, 0, 1, 32'h3A00, 0, 0);
    step(0, 1, 32'h3B00, 0, 0, 0, 0);
    n_cmp++; if (pc_F !== 32'h3A00 || obs_sel !== 2'd2) begin n_err++; $display("FAIL pend_beats_br: got pc=%h sel=%0d want 3a00/2", pc_F, obs_sel); end
  endtask

  task automatic test_align_reset();
    step(0, 0, 0, 0, 0, 1, 32'h3502);
    n_cmp++; if (pc_F !== 32'h3500 || align_err !== 1'b1) begin n_err++; $display("FAIL align: got pc=%h err=%b want 3500/1", pc_F, align_err); end
    step(1, 0, 0, 1, 32'h3C00, 0, 0);
    n_cmp++; if (pend_vld !== 1'b1) begin n_err++; $display("FAIL pend_before_rst: got %b want 1", pend_vld); end
    do_reset();
    n_cmp++; if (pc_F !== 32'h3000 || {pend_vld, align_err, multi_err} !== 3'b000 || redir_cnt !== 4'd0) begin
      n_err++; $display("FAIL rst_in_pend: got pc=%h flags=%b cnt=%0d want 3000/000/0", pc_F, {pend_vld, align_err, multi_err}, redir_cnt); end
    release_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc_F !== 32'h3004 || obs_sel !== 2'd0) begin n_err++; $display("FAIL pend_discard: got pc=%h sel=%0d want 3004/0", pc_F, obs_sel); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) step(0, 1, 32'h4000 + 32'(i) * 32'd16, 0, 0, 0, 0);
    n_cmp++; if (redir_cnt !== 4'(CNT_MAX)) begin n_err++; $display("FAIL cnt_sat: got %0d want %0d", redir_cnt, CNT_MAX); end
    n_cmp++; if (pc_F !== 32'h4130) begin n_err++; $display("FAIL sat_pc: got %h want 4130", pc_F); end
  endtask

  task automatic test_random();
    logic [31:0] t [3];
    bit st, b, j, r;
    do_reset();
    release_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        t[k] = $urandom;
        t[k][31:16] = 16'h0;
        if ($urandom_range(0, 3) != 0) t[k][1:0] = 2'b00;
      end
      st = ($urandom_range(0, 9) < 4);
      b = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 5) == 0);
      step(st, b, t[0], j, t[1], r, t[2]);
      n_cmp++; if (obs_sel !== 2'(exp_sel)) begin n_err++; $display("FAIL rnd_sel @%0d: got %0d want %0d", n, obs_sel, exp_sel); end
      n_cmp++; if (pc_F !== m_pc) begin n_err++; $display("FAIL rnd_pc @%0d: got %h want %h", n, pc_F, m_pc); end
      n_cmp++; if (pc_plus4_F !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_plus4 @%0d: got %h want %h", n, pc_plus4_F, m_pc + 32'd4); end
      n_cmp++; if (pend_vld !== m_pend) begin n_err++; $display("FAIL rnd_pend @%0d: got %b want %b", n, pend_vld, m_pend); end
      n_cmp++; if (align_err !== m_align || multi_err !== m_multi) begin n_err++; $display("FAIL rnd_flags @%0d: got %b%b want %b%b", n, align_err, multi_err, m_align, m_multi); end
      n_cmp++; if (redir_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, redir_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential_and_branch();
    test_multi();
    test_stall_redirect();
    test_pend_priority();
    test_align_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
